// File: rtl/resource_lease_ctrl.sv
// resource_lease_ctrl
//   Downstream stage of the three-requester arbiter (IDs A=01, B=10, C=11).
//   It accepts one grant at a time. It holds the shared 2-bit owner register
//   for a programmed number of cycles, then runs a cooldown before it accepts
//   the next grant. A release pulse tells the arbiter that the lease ended, so
//   the arbiter can pop its queue. Completed leases are counted per requester.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   grant_valid/grant_id       grant from arbiter (ID 00 is invalid)
//   hold_cycles/cool_cycles    lease and cooldown lengths, sampled at accept
//   grant_ready                high only while idle
//   abort                      ends the lease early while holding
//   owner                      current owner ID, 00 when the resource is free
//   busy                       high in HOLD or COOLDOWN
//   release_valid/_id/_abort   one-cycle release report
//   id_err                     one-cycle pulse: invalid grant accepted and dropped
//   lease_cnt_a/b/c            saturating counts of completed leases
module resource_lease_ctrl #(
  parameter int CNT_W  = 4,
  parameter int STAT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              grant_valid,
  input  logic [1:0]        grant_id,
  input  logic [CNT_W-1:0]  hold_cycles,
  input  logic [CNT_W-1:0]  cool_cycles,
  output logic              grant_ready,
  input  logic              abort,
  output logic [1:0]        owner,
  output logic              busy,
  output logic              release_valid,
  output logic [1:0]        release_id,
  output logic              release_abort,
  output logic              id_err,
  output logic [STAT_W-1:0] lease_cnt_a,
  output logic [STAT_W-1:0] lease_cnt_b,
  output logic [STAT_W-1:0] lease_cnt_c
);

  typedef enum logic [1:0] {IDLE, HOLD, COOLDOWN} stateT;

  stateT            state, stateNext;
  logic [CNT_W-1:0] holdTimer, holdTimerNext;
  logic [CNT_W-1:0] coolTimer, coolTimerNext;
  logic [1:0]       ownerNext;
  logic             relValidNext;
  logic [1:0]       relIdNext;
  logic             relAbortNext;
  logic             idErrNext;
  logic [2:0]       countInc;

  // Next-state and next-output logic. The hold timer holds the number of HOLD
  // cycles that remain, including the current one. A value of 1 therefore marks
  // the last HOLD cycle. The cool timer works the same way in COOLDOWN.
  // An abort takes priority over a natural end in the same cycle, so an
  // aborted lease never increments its counter.
  always_comb begin
    stateNext     = state;
    holdTimerNext = holdTimer;
    coolTimerNext = coolTimer;
    ownerNext     = owner;
    relValidNext  = 1'b0;
    relIdNext     = 2'b00;
    relAbortNext  = 1'b0;
    idErrNext     = 1'b0;
    countInc      = 3'b000;
    case (state)
      IDLE: begin
        if (grant_valid && grant_ready) begin
          if (grant_id == 2'b00) begin
            idErrNext = 1'b1;
          end else begin
            ownerNext     = grant_id;
            holdTimerNext = (hold_cycles == '0) ? CNT_W'(1) : hold_cycles;
            coolTimerNext = cool_cycles;
            stateNext     = HOLD;
          end
        end
      end
      HOLD: begin
        holdTimerNext = holdTimer - 1'b1;
        if (abort || holdTimer == CNT_W'(1)) begin
          holdTimerNext = '0;
          ownerNext     = 2'b00;
          relValidNext  = 1'b1;
          relIdNext     = owner;
          relAbortNext  = abort;
          if (!abort) begin
            countInc = {owner == 2'b11, owner == 2'b10, owner == 2'b01};
          end
          stateNext = (coolTimer == '0) ? IDLE : COOLDOWN;
        end
      end
      COOLDOWN: begin
        coolTimerNext = coolTimer - 1'b1;
        if (coolTimer <= CNT_W'(1)) begin
          coolTimerNext = '0;
          stateNext     = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // State and output registers. busy and grant_ready come from the next state,
  // so they change in the same cycle as the state. When the cooldown is zero,
  // this lets grant_ready rise together with the release pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      holdTimer     <= '0;
      coolTimer     <= '0;
      owner         <= 2'b00;
      busy          <= 1'b0;
      grant_ready   <= 1'b1;
      release_valid <= 1'b0;
      release_id    <= 2'b00;
      release_abort <= 1'b0;
      id_err        <= 1'b0;
    end else begin
      state         <= stateNext;
      holdTimer     <= holdTimerNext;
      coolTimer     <= coolTimerNext;
      owner         <= ownerNext;
      busy          <= (stateNext != IDLE);
      grant_ready   <= (stateNext == IDLE);
      release_valid <= relValidNext;
      release_id    <= relIdNext;
      release_abort <= relAbortNext;
      id_err        <= idErrNext;
    end
  end

  // Per-requester lease counters. Each counter stops at all-ones and does not wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lease_cnt_a <= '0;
      lease_cnt_b <= '0;
      lease_cnt_c <= '0;
    end else begin
      if (countInc[0] && lease_cnt_a != '1) lease_cnt_a <= lease_cnt_a + 1'b1;
      if (countInc[1] && lease_cnt_b != '1) lease_cnt_b <= lease_cnt_b + 1'b1;
      if (countInc[2] && lease_cnt_c != '1) lease_cnt_c <= lease_cnt_c + 1'b1;
    end
  end

endmodule
